// File: rtl/rename_pkg.sv
// Shared rename-stage constants, tag type and free-list FSM encodings.
// Pure declarations: no latency, no flow control.
// Consumers size their own ports from these defaults.
package rename_pkg;
    localparam int PROJ_LOG_PHYS      = 6;
    localparam int PROJ_NUM_PHYS      = 64;
    localparam int PROJ_NUM_ARCH_REGS = 32;

    typedef logic [PROJ_LOG_PHYS-1:0] phys_tag_t;

    typedef enum logic [1:0] {
        FL_INIT    = 2'd0,
        FL_READY   = 2'd1,
        FL_RECOVER = 2'd2
    } fl_state_t;
endpackage

// File: rtl/free_list_ram.sv
// Tag storage for the free list: one write port, one asynchronous read port.
// Write lands on the rising edge; read is combinational. No backpressure.
// Data is deliberately not reset; the controller initialises every entry it reads.
module free_list_ram #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 6,
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/phys_free_list_ctrl.sv
// Physical-register free list with speculative and committed heads, flush rewind.
// Head tag combinational from storage; alloc/release visible the cycle after.
// No stall: illegal alloc pulses Underflow_ERR, release into a full list pulses Overflow_ERR.
module phys_free_list_ctrl
    import rename_pkg::*;
#(
    parameter int NUM_PHYS = PROJ_NUM_PHYS,
    parameter int LOG_PHYS = PROJ_LOG_PHYS,
    parameter int NUM_ARCH = PROJ_NUM_ARCH_REGS
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Alloc_IN,
    input  logic                Commit_alloc_IN,
    input  logic                Release_valid_IN,
    input  logic [LOG_PHYS-1:0] Release_reg_IN,
    input  logic                Flush_IN,
    output logic [LOG_PHYS-1:0] Free_phys_reg,
    output logic                Free_reg_avail,
    output logic [LOG_PHYS:0]   Free_count,
    output logic                Init_done,
    output logic                Underflow_ERR,
    output logic                Overflow_ERR
);
    localparam int                  INIT_N    = NUM_PHYS - NUM_ARCH;
    localparam logic [LOG_PHYS-1:0] INIT_LAST = LOG_PHYS'(INIT_N - 1);
    localparam logic [LOG_PHYS-1:0] INIT_TAIL = LOG_PHYS'(INIT_N);
    localparam logic [LOG_PHYS:0]   INIT_CNT  = (LOG_PHYS+1)'(INIT_N);
    localparam logic [LOG_PHYS:0]   FULL_CNT  = (LOG_PHYS+1)'(NUM_PHYS);

    fl_state_t           state, state_nx;
    logic [LOG_PHYS-1:0] spec_head, commit_head, tail, init_cnt;
    logic [LOG_PHYS:0]   spec_count, commit_count;
    logic                underflow_q, overflow_q;

    logic                active, flush_go, alloc_go, commit_go, rel_req, rel_go, full;
    logic [LOG_PHYS-1:0] commit_head_nx;
    logic [LOG_PHYS:0]   commit_count_nx;
    logic                ram_wr_en;
    logic [LOG_PHYS-1:0] ram_wr_addr, ram_wr_dat, ram_rd_dat;

    assign active    = (state != FL_INIT);
    assign full      = (commit_count == FULL_CNT);
    assign flush_go  = active && Flush_IN;
    // Flush takes priority over a same-cycle allocation; the allocation is simply dropped.
    assign alloc_go  = (state == FL_READY) && Alloc_IN && Free_reg_avail && !Flush_IN;
    assign commit_go = active && Commit_alloc_IN;
    // Tag 0 is permanently bound to arch $0 and never re-enters the list.
    assign rel_req   = active && Release_valid_IN && (Release_reg_IN != '0);
    assign rel_go    = rel_req && !full;

    assign commit_head_nx  = commit_head + LOG_PHYS'(commit_go);
    assign commit_count_nx = commit_count + (LOG_PHYS+1)'(rel_go) - (LOG_PHYS+1)'(commit_go);

    always_comb begin
        state_nx = state;
        case (state)
            FL_INIT:    if (init_cnt == INIT_LAST) state_nx = FL_READY;
            FL_READY:   if (Flush_IN) state_nx = FL_RECOVER;
            FL_RECOVER: if (!Flush_IN) state_nx = FL_READY;
            default:    state_nx = FL_INIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= FL_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            spec_head    <= '0;
            commit_head  <= '0;
            tail         <= '0;
            init_cnt     <= '0;
            spec_count   <= '0;
            commit_count <= '0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (state == FL_INIT) begin
            init_cnt    <= init_cnt + LOG_PHYS'(1);
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            if (init_cnt == INIT_LAST) begin
                tail         <= INIT_TAIL;
                spec_count   <= INIT_CNT;
                commit_count <= INIT_CNT;
            end
        end else begin
            if (rel_go) begin
                tail <= tail + LOG_PHYS'(1);
            end
            commit_head  <= commit_head_nx;
            commit_count <= commit_count_nx;
            // Rewind sees the committed state including this cycle's commit/release.
            if (flush_go) begin
                spec_head  <= commit_head_nx;
                spec_count <= commit_count_nx;
            end else begin
                spec_head  <= spec_head + LOG_PHYS'(alloc_go);
                spec_count <= spec_count + (LOG_PHYS+1)'(rel_go) - (LOG_PHYS+1)'(alloc_go);
            end
            underflow_q <= Alloc_IN && !Free_reg_avail && !Flush_IN;
            overflow_q  <= rel_req && full;
        end
    end

    assign ram_wr_en   = (state == FL_INIT) || rel_go;
    assign ram_wr_addr = (state == FL_INIT) ? init_cnt : tail;
    assign ram_wr_dat  = (state == FL_INIT) ? (LOG_PHYS'(NUM_ARCH) + init_cnt) : Release_reg_IN;

    free_list_ram #(
        .DEPTH  (NUM_PHYS),
        .WIDTH  (LOG_PHYS),
        .ADDR_W (LOG_PHYS)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_dat),
        .rd_addr (spec_head),
        .rd_data (ram_rd_dat)
    );

    assign Free_phys_reg  = active ? ram_rd_dat : '0;
    assign Free_reg_avail = (state == FL_READY) && (spec_count != '0);
    assign Free_count     = spec_count;
    assign Init_done      = active;
    assign Underflow_ERR  = underflow_q;
    assign Overflow_ERR   = overflow_q;
endmodule

// File: tb/tb_phys_free_list_ctrl.sv
// Directed bench for phys_free_list_ctrl: vector table plus hand-written corner sequences.
module tb_phys_free_list_ctrl;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       Alloc_IN, Commit_alloc_IN, Release_valid_IN, Flush_IN;
    logic [5:0] Release_reg_IN;
    logic [5:0] Free_phys_reg;
    logic       Free_reg_avail;
    logic [6:0] Free_count;
    logic       Init_done, Underflow_ERR, Overflow_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    phys_free_list_ctrl dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .Alloc_IN         (Alloc_IN),
        .Commit_alloc_IN  (Commit_alloc_IN),
        .Release_valid_IN (Release_valid_IN),
        .Release_reg_IN   (Release_reg_IN),
        .Flush_IN         (Flush_IN),
        .Free_phys_reg    (Free_phys_reg),
        .Free_reg_avail   (Free_reg_avail),
        .Free_count       (Free_count),
        .Init_done        (Init_done),
        .Underflow_ERR    (Underflow_ERR),
        .Overflow_ERR     (Overflow_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       alloc, commit, rel_vld;
        logic [5:0] rel_reg;
        logic       flush;
        logic       e_avail;
        logic [5:0] e_reg;
        logic [6:0] e_cnt;
        logic       e_uf, e_of;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mkv(logic a, logic c, logic rv, logic [5:0] rr, logic f,
                                 logic ea, logic [5:0] er, logic [6:0] ec, logic eu, logic eo);
        vec_t v;
        v.alloc = a; v.commit = c; v.rel_vld = rv; v.rel_reg = rr; v.flush = f;
        v.e_avail = ea; v.e_reg = er; v.e_cnt = ec; v.e_uf = eu; v.e_of = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Alloc_IN = 0; Commit_alloc_IN = 0; Release_valid_IN = 0; Release_reg_IN = '0; Flush_IN = 0;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!Init_done && n < 100) begin
            step();
            n++;
        end
        check({name, " init latency"}, n, 32);
    endtask

    task automatic reset_init(input string name);
        idle_inputs();
        RESET = 1;
        step();
        RESET = 0;
        wait_init(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 4 plus flush-in-recover, tag-0 release and alloc+release, from a fresh list
        vecs[0]  = mkv(1,0,0, 0,0, 1,33,31,0,0);
        vecs[1]  = mkv(1,0,0, 0,0, 1,34,30,0,0);
        vecs[2]  = mkv(1,0,0, 0,0, 1,35,29,0,0);
        vecs[3]  = mkv(1,0,0, 0,0, 1,36,28,0,0);
        vecs[4]  = mkv(0,1,0, 0,0, 1,36,28,0,0);
        vecs[5]  = mkv(0,1,0, 0,0, 1,36,28,0,0);
        vecs[6]  = mkv(0,0,0, 0,1, 0,34,30,0,0);
        vecs[7]  = mkv(0,0,0, 0,0, 1,34,30,0,0);
        vecs[8]  = mkv(0,0,1, 0,0, 1,34,30,0,0);
        vecs[9]  = mkv(1,0,1,12,0, 1,35,30,0,0);
        vecs[10] = mkv(1,0,0, 0,1, 0,34,31,0,0);
        vecs[11] = mkv(0,0,1,13,1, 0,34,32,0,0);
        vecs[12] = mkv(0,0,0, 0,0, 1,34,32,0,0);

        idle_inputs();
        RESET = 1;
        step();
        step();
        check("reset avail", Free_reg_avail, 0);
        check("reset reg", Free_phys_reg, 0);
        check("reset count", Free_count, 0);
        check("reset init_done", Init_done, 0);
        check("reset underflow", Underflow_ERR, 0);
        check("reset overflow", Overflow_ERR, 0);

        // Test 1: initialisation
        RESET = 0;
        wait_init("t1");
        check("t1 count", Free_count, 32);
        check("t1 reg", Free_phys_reg, 32);
        check("t1 avail", Free_reg_avail, 1);

        // Test 2: drain the list in order, then underflow
        Alloc_IN = 1;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t2 tag%0d", i), Free_phys_reg, 32 + i);
            step();
        end
        Alloc_IN = 0;
        check("t2 empty avail", Free_reg_avail, 0);
        check("t2 empty count", Free_count, 0);
        Alloc_IN = 1;
        step();
        Alloc_IN = 0;
        check("t2 underflow pulse", Underflow_ERR, 1);
        check("t2 underflow count", Free_count, 0);
        step();
        check("t2 underflow clears", Underflow_ERR, 0);

        // Test 3: release into empty list, then alloc+release
        Release_valid_IN = 1; Release_reg_IN = 6'd5;
        check("t3 avail same cycle", Free_reg_avail, 0);
        step();
        Release_valid_IN = 0;
        check("t3 avail next", Free_reg_avail, 1);
        check("t3 reg", Free_phys_reg, 5);
        check("t3 count", Free_count, 1);
        Alloc_IN = 1; Release_valid_IN = 1; Release_reg_IN = 6'd9;
        step();
        idle_inputs();
        check("t3 alloc+rel count", Free_count, 1);
        check("t3 alloc+rel reg", Free_phys_reg, 9);
        check("t3 alloc+rel underflow", Underflow_ERR, 0);

        // Vector table
        reset_init("tab");
        for (int i = 0; i < 13; i++) begin
            Alloc_IN = vecs[i].alloc; Commit_alloc_IN = vecs[i].commit;
            Release_valid_IN = vecs[i].rel_vld; Release_reg_IN = vecs[i].rel_reg;
            Flush_IN = vecs[i].flush;
            step();
            check($sformatf("vec%0d avail", i), Free_reg_avail, vecs[i].e_avail);
            check($sformatf("vec%0d reg", i), Free_phys_reg, vecs[i].e_reg);
            check($sformatf("vec%0d count", i), Free_count, vecs[i].e_cnt);
            check($sformatf("vec%0d underflow", i), Underflow_ERR, vecs[i].e_uf);
            check($sformatf("vec%0d overflow", i), Overflow_ERR, vecs[i].e_of);
        end
        idle_inputs();

        // Test 5: fill, overflow, pointer wrap
        reset_init("t5");
        Release_valid_IN = 1;
        for (int i = 1; i <= 32; i++) begin
            Release_reg_IN = 6'(i);
            step();
        end
        check("t5 full count", Free_count, 64);
        Release_reg_IN = 6'd40;
        step();
        Release_valid_IN = 0;
        check("t5 overflow pulse", Overflow_ERR, 1);
        check("t5 overflow count", Free_count, 64);
        step();
        check("t5 overflow clears", Overflow_ERR, 0);
        Alloc_IN = 1;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("t5 order%0d", i), Free_phys_reg, (i < 32) ? 32 + i : i - 31);
            step();
        end
        Alloc_IN = 0;
        check("t5 drained avail", Free_reg_avail, 0);
        Commit_alloc_IN = 1;
        step();
        Commit_alloc_IN = 0;
        Release_valid_IN = 1; Release_reg_IN = 6'd7;
        step();
        idle_inputs();
        check("t5 wrap reg", Free_phys_reg, 7);
        check("t5 wrap avail", Free_reg_avail, 1);
        check("t5 wrap count", Free_count, 1);

        // Test 6: reset mid-alloc, init restarts, tag-0 release
        reset_init("t6");
        Alloc_IN = 1;
        step(); step(); step();
        check("t6 pre-reset reg", Free_phys_reg, 35);
        RESET = 1;
        step();
        check("t6 reset reg", Free_phys_reg, 0);
        check("t6 reset count", Free_count, 0);
        check("t6 reset avail", Free_reg_avail, 0);
        check("t6 reset init_done", Init_done, 0);
        check("t6 reset errs", {Underflow_ERR, Overflow_ERR}, 0);
        Alloc_IN = 0;
        RESET = 0;
        wait_init("t6 restart");
        check("t6 restart reg", Free_phys_reg, 32);
        Release_valid_IN = 1; Release_reg_IN = 6'd0;
        step();
        idle_inputs();
        check("t6 tag0 count", Free_count, 32);
        check("t6 tag0 overflow", Overflow_ERR, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
